// File: rtl/rf_op_sequencer.sv
// rtl/rf_op_sequencer.sv - multi-cycle read/execute/write-back sequencer for a 2R1W register file
module rf_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_src1,
  input  logic [ADDR_W-1:0] req_src2,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic              req_we,
  output logic [ADDR_W-1:0] rs,
  output logic [ADDR_W-1:0] rt,
  input  logic [DATA_W-1:0] crs,
  input  logic [DATA_W-1:0] crt,
  output logic [ADDR_W-1:0] rw,
  output logic [DATA_W-1:0] dw,
  output logic              rwe,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int SHW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_SLL  = 3'd6;

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   rs_q, rt_q, rw_q, dst_q;
  logic                we_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic [DATA_W-1:0]   result_q;
  logic                done_q;

  // Next state and the combinational handshake/write-enable outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rwe       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = READ;
      end
      READ:  state_d = EXEC;
      EXEC:  state_d = WRITE;
      WRITE: begin
        rwe     = we_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_d = '0;
    case (op_q)
      OP_ADD: alu_d = a_q + b_q;
      OP_SUB: alu_d = a_q - b_q;
      OP_AND: alu_d = a_q & b_q;
      OP_OR:  alu_d = a_q | b_q;
      OP_XOR: alu_d = a_q ^ b_q;
      OP_SLT: alu_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL: alu_d = a_q << b_q[SHW-1:0];
      default: alu_d = a_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rw_q     <= '0;
      dst_q    <= '0;
      we_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          op_q  <= req_op;
          rs_q  <= req_src1;
          rt_q  <= req_src2;
          dst_q <= req_dst;
          we_q  <= req_we;
        end
        READ: begin
          a_q <= crs;
          b_q <= crt;
        end
        EXEC: begin
          alu_q <= alu_d;
          rw_q  <= dst_q;
        end
        WRITE: begin
          result_q <= alu_q;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Address registers only change on accept/exec, so they hold steady through IDLE.
  assign rs     = rs_q;
  assign rt     = rt_q;
  assign rw     = rw_q;
  assign dw     = alu_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// tb/tb_rf_op_sequencer.sv - directed self-checking bench with a behavioural register file
module tb_rf_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_src1, req_src2, req_dst;
  logic        req_we;
  logic [4:0]  rs, rt, rw;
  logic [31:0] crs, crt, dw, result;
  logic        rwe, done;

  logic [31:0] regs [32];
  logic        tb_we;
  logic [4:0]  tb_wa;
  logic [31:0] tb_wd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_op_sequencer #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst), .req_we(req_we),
    .rs(rs), .rt(rt), .crs(crs), .crt(crt),
    .rw(rw), .dw(dw), .rwe(rwe), .done(done), .result(result)
  );

  assign crs = regs[rs];
  assign crt = regs[rt];

  always @(posedge clk) begin
    if (rwe) regs[rw] <= dw;
    else if (tb_we) regs[tb_wa] <= tb_wd;
  end

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk); @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Issue one op from a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic do_op(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic we,
                       output int lat, output int wr, output logic [31:0] res);
    req_op = op; req_src1 = s1; req_src2 = s2; req_dst = d; req_we = we;
    req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    lat = 0; wr = 0;
    for (int k = 1; k <= 10; k++) begin
      if (rwe) wr++;
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk); @(negedge clk);
    end
    res = result;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_checks++; if (rwe !== 1'b0) begin n_fail++; $display("FAIL reset_rwe got %b want 0", rwe); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    n_checks++; if ({rs, rt, rw} !== 15'h0) begin n_fail++; $display("FAIL reset_addr got %h/%h/%h want 0", rs, rt, rw); end
    n_checks++; if (dw !== 32'h0) begin n_fail++; $display("FAIL reset_dw got %h want 0", dw); end
  endtask

  task automatic test_add;
    int lat, wr; logic [31:0] res;
    do_op(3'd0, 5'd1, 5'd2, 5'd10, 1'b1, lat, wr, res);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency got %0d want 4", lat); end
    n_checks++; if (res !== 32'h7B7) begin n_fail++; $display("FAIL add_result got %h want 000007b7", res); end
    n_checks++; if (regs[10] !== 32'h7B7) begin n_fail++; $display("FAIL add_r10 got %h want 000007b7", regs[10]); end
    n_checks++; if (wr !== 1) begin n_fail++; $display("FAIL add_rwe_cycles got %0d want 1", wr); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready_on_done got %b want 1", req_ready); end
  endtask

  task automatic test_back_to_back;
    int lat, wr; logic [31:0] res;
    do_op(3'd1, 5'd10, 5'd2, 5'd11, 1'b1, lat, wr, res);
    n_checks++; if (res !== 32'h70D) begin n_fail++; $display("FAIL sub_result got %h want 0000070d", res); end
    do_op(3'd5, 5'd11, 5'd1, 5'd12, 1'b1, lat, wr, res);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL b2b_latency got %0d want 4", lat); end
    n_checks++; if (regs[11] !== 32'h70D) begin n_fail++; $display("FAIL b2b_r11 got %h want 0000070d", regs[11]); end
    n_checks++; if (regs[12] !== 32'h0) begin n_fail++; $display("FAIL b2b_r12 got %h want 0", regs[12]); end
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL slt_eq_result got %h want 0", res); end
  endtask

  task automatic test_no_write;
    int lat, wr; logic [31:0] res;
    do_op(3'd4, 5'd1, 5'd2, 5'd5, 1'b0, lat, wr, res);
    n_checks++; if (res !== 32'h7A7) begin n_fail++; $display("FAIL xor_result got %h want 000007a7", res); end
    n_checks++; if (wr !== 0) begin n_fail++; $display("FAIL nowe_rwe_cycles got %0d want 0", wr); end
    n_checks++; if (regs[5] !== 32'h55) begin n_fail++; $display("FAIL nowe_r5 got %h want 00000055", regs[5]); end
    do_op(3'd2, 5'd1, 5'd2, 5'd5, 1'b0, lat, wr, res);
    n_checks++; if (res !== 32'h8) begin n_fail++; $display("FAIL and_result got %h want 00000008", res); end
    do_op(3'd3, 5'd1, 5'd2, 5'd5, 1'b0, lat, wr, res);
    n_checks++; if (res !== 32'h7AF) begin n_fail++; $display("FAIL or_result got %h want 000007af", res); end
    do_op(3'd7, 5'd2, 5'd1, 5'd5, 1'b0, lat, wr, res);
    n_checks++; if (res !== 32'hAA) begin n_fail++; $display("FAIL pass_result got %h want 000000aa", res); end
  endtask

  task automatic test_boundaries;
    int lat, wr; logic [31:0] res;
    preload(5'd3, 32'hFFFF_FFFF);
    preload(5'd4, 32'h1);
    preload(5'd6, 32'h8000_0000);
    preload(5'd7, 32'd37);
    do_op(3'd0, 5'd3, 5'd4, 5'd20, 1'b1, lat, wr, res);
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL add_wrap got %h want 0", res); end
    n_checks++; if (regs[20] !== 32'h0) begin n_fail++; $display("FAIL add_wrap_r20 got %h want 0", regs[20]); end
    do_op(3'd5, 5'd6, 5'd4, 5'd21, 1'b1, lat, wr, res);
    n_checks++; if (res !== 32'h1) begin n_fail++; $display("FAIL slt_signed got %h want 1", res); end
    do_op(3'd6, 5'd4, 5'd7, 5'd31, 1'b1, lat, wr, res);
    n_checks++; if (res !== 32'h20) begin n_fail++; $display("FAIL sll_mask got %h want 00000020", res); end
    n_checks++; if (regs[31] !== 32'h20) begin n_fail++; $display("FAIL dst31 got %h want 00000020", regs[31]); end
    n_checks++; if (rw !== 5'd31) begin n_fail++; $display("FAIL rw_hold got %0d want 31", rw); end
  endtask

  task automatic test_reset_mid_op;
    int lat, wr, bad; logic [31:0] res;
    preload(5'd13, 32'h1234);
    req_op = 3'd0; req_src1 = 5'd1; req_src2 = 5'd2; req_dst = 5'd13; req_we = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle got %b want 1", req_ready); end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (rwe || done) bad++;
      @(posedge clk); @(negedge clk);
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL abort_quiet got %0d want 0", bad); end
    n_checks++; if (regs[13] !== 32'h1234) begin n_fail++; $display("FAIL abort_r13 got %h want 00001234", regs[13]); end
    do_op(3'd0, 5'd1, 5'd2, 5'd13, 1'b1, lat, wr, res);
    n_checks++; if (lat !== 4 || res !== 32'h7B7) begin n_fail++; $display("FAIL after_abort got lat %0d res %h want 4 000007b7", lat, res); end
    n_checks++; if (regs[13] !== 32'h7B7) begin n_fail++; $display("FAIL after_abort_r13 got %h want 000007b7", regs[13]); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
    req_dst = '0; req_we = 1'b0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    @(negedge clk);
    test_reset;
    preload(5'd1, 32'h0000_070D);
    preload(5'd2, 32'h0000_00AA);
    preload(5'd5, 32'h0000_0055);
    test_add;
    test_back_to_back;
    test_no_write;
    test_boundaries;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
